cpu_sequencer: RTL

//  Multi-cycle Hack-style fetch/decode/execute sequencer; direct upstream driver of memory_controller.

---
 rtl/luna_pkg.sv | 37 +++
 rtl/hack_alu.sv | 32 +++
 rtl/cpu_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/luna_pkg.sv
// Shared encodings for the Hack-style sequencer: FSM states, instruction
// field positions, destination/jump bit indices and ALU control bit names.
package luna_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MWAIT,
    WB,
    HALT
  } seq_state_t;

  // Instruction word fields
  localparam int INSTR_TYPE = 15;
  localparam int INSTR_A    = 12;
  localparam int COMP_HI    = 11;
  localparam int COMP_LO    = 6;

  // Destination bits (A, D, M)
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  // Jump condition bits (lt, eq, gt)
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  // ALU control bit positions within the 6-bit comp field
  localparam int ALU_ZX = 5;
  localparam int ALU_NX = 4;
  localparam int ALU_ZY = 3;
  localparam int ALU_NY = 2;
  localparam int ALU_F  = 1;
  localparam int ALU_NO = 0;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/negate on each operand, add or AND,
// optional output negate, with zero and negative flags. 16-bit wrap.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z;
  logic [15:0] x_n;
  logic [15:0] y_z;
  logic [15:0] y_n;
  logic [15:0] res;

  assign x_z = zx ? 16'h0000 : x;
  assign x_n = nx ? ~x_z : x_z;
  assign y_z = zy ? 16'h0000 : y;
  assign y_n = ny ? ~y_z : y_z;
  assign res = f ? (x_n + y_n) : (x_n & y_n);
  assign out = no ? ~res : res;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the A/D/M writeback
// strobes of memory_controller; owns the program counter and jump logic.
module cpu_sequencer #(
  parameter int PC_W  = 15,
  parameter int M_LAT = 2
) (
  input  logic            wrbk_clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  input  logic [15:0]     reg_a_in,
  input  logic [15:0]     reg_d_in,
  input  logic [15:0]     reg_m_in,
  output logic [15:0]     data_out,
  output logic            reg_a_en,
  output logic            reg_d_en,
  output logic            reg_m_en,
  output logic [PC_W-1:0] pc,
  output logic            halted
);
  import luna_pkg::*;

  seq_state_t      state_reg;
  logic [15:0]     instr_reg;
  logic [2:0]      cnt_reg;
  logic [PC_W-1:0] pc_reg;
  logic [15:0]     data_out_reg;
  logic            reg_a_en_reg;
  logic            reg_d_en_reg;
  logic            reg_m_en_reg;
  logic            halted_reg;

  logic [5:0]      comp;
  logic [15:0]     alu_y;
  logic [15:0]     alu_out;
  logic            alu_zr;
  logic            alu_ng;
  logic            jump_take;

  assign comp  = instr_reg[COMP_HI:COMP_LO];
  assign alu_y = instr_reg[INSTR_A] ? reg_m_in : reg_a_in;

  hack_alu u_alu (
    .x   (reg_d_in),
    .y   (alu_y),
    .zx  (comp[ALU_ZX]),
    .nx  (comp[ALU_NX]),
    .zy  (comp[ALU_ZY]),
    .ny  (comp[ALU_NY]),
    .f   (comp[ALU_F]),
    .no  (comp[ALU_NO]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump_take = (instr_reg[JMP_LT] & alu_ng)
                   | (instr_reg[JMP_EQ] & alu_zr)
                   | (instr_reg[JMP_GT] & ~alu_ng & ~alu_zr);

  // The sync ROM presents ROM[pc] one cycle after FETCH, so the word is
  // classified and captured during DECODE.
  always_ff @(posedge wrbk_clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      instr_reg    <= 16'h0000;
      cnt_reg      <= 3'd0;
      pc_reg       <= '0;
      data_out_reg <= 16'h0000;
      reg_a_en_reg <= 1'b0;
      reg_d_en_reg <= 1'b0;
      reg_m_en_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      reg_a_en_reg <= 1'b0;
      reg_d_en_reg <= 1'b0;
      reg_m_en_reg <= 1'b0;
      case (state_reg)
        FETCH: state_reg <= DECODE;
        DECODE: begin
          instr_reg <= rom_data;
          if (rom_data[INSTR_TYPE] && rom_data[INSTR_A] && (M_LAT > 0)) begin
            cnt_reg   <= 3'(M_LAT - 1);
            state_reg <= MWAIT;
          end else begin
            state_reg <= WB;
          end
        end
        MWAIT: begin
          if (cnt_reg == 3'd0) state_reg <= WB;
          else                 cnt_reg   <= cnt_reg - 3'd1;
        end
        WB: begin
          if (!instr_reg[INSTR_TYPE]) begin
            data_out_reg <= {1'b0, instr_reg[14:0]};
            reg_a_en_reg <= 1'b1;
            pc_reg       <= pc_reg + 1'b1;
          end else begin
            // Jump target is the A value seen before this writeback lands.
            data_out_reg <= alu_out;
            reg_a_en_reg <= instr_reg[DEST_A];
            reg_d_en_reg <= instr_reg[DEST_D];
            reg_m_en_reg <= instr_reg[DEST_M];
            pc_reg       <= jump_take ? reg_a_in[PC_W-1:0] : pc_reg + 1'b1;
          end
          if (run) begin
            state_reg <= FETCH;
          end else begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end
        end
        HALT: begin
          if (run) begin
            state_reg  <= FETCH;
            halted_reg <= 1'b0;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign rom_addr = pc_reg;
  assign pc       = pc_reg;
  assign data_out = data_out_reg;
  assign reg_a_en = reg_a_en_reg;
  assign reg_d_en = reg_d_en_reg;
  assign reg_m_en = reg_m_en_reg;
  assign halted   = halted_reg;

endmodule
